// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: the history-table geometry and the
// record kept for every in-flight predicted branch.
package bp_pkg;

  localparam int HISTORY_WIDTH = 3;
  localparam int PC_WIDTH      = 10;

  typedef logic [1:0] rec_t;

  typedef struct packed {
    logic [HISTORY_WIDTH-1:0] idx;
    rec_t                     rec;
    logic [PC_WIDTH-1:0]      target;
    logic [PC_WIDTH-1:0]      fall;
  } bq_entry_t;

  // The counter's upper bit is the direction the table predicted.
  function automatic logic pred_taken(rec_t r);
    return r[1];
  endfunction

endpackage

// File: rtl/bq_fifo.sv
// Circular buffer of branch records. Head is the oldest entry and is always
// visible; clear drops every entry and wins over push/pop in the same cycle.
module bq_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  bq_entry_t                  din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output bq_entry_t                  head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bq_entry_t        mem [DEPTH];
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [CW-1:0]    cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= din;
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[head_ptr];

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches in fetch order, turns each resolution of the oldest
// one into a history-table update, and redirects fetch on a misprediction.
module branch_resolve_queue #(
  parameter int HISTORY_WIDTH = bp_pkg::HISTORY_WIDTH,
  parameter int DEPTH         = 4,
  parameter int PC_WIDTH      = bp_pkg::PC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [HISTORY_WIDTH-1:0] push_idx,
  input  logic [1:0]               push_rec,
  input  logic [PC_WIDTH-1:0]      push_target,
  input  logic [PC_WIDTH-1:0]      push_fall,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     upd,
  output logic [HISTORY_WIDTH-1:0] upd_addr,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     err
);

  import bp_pkg::*;

  bq_entry_t push_entry;
  bq_entry_t head_entry;
  logic      fifo_full;
  logic      fifo_empty;
  logic      do_resolve;
  logic      wrong;
  logic      fifo_clear;
  logic      fifo_push;

  assign push_entry = '{idx: push_idx, rec: push_rec, target: push_target, fall: push_fall};

  // A mispredict squashes everything younger, including a same-cycle push.
  assign do_resolve = resolve && !fifo_empty;
  assign wrong      = do_resolve && (pred_taken(head_entry.rec) != resolve_taken);
  assign fifo_clear = flush || wrong;
  assign fifo_push  = push && (!fifo_full || do_resolve) && !fifo_clear;

  bq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (do_resolve),
    .clear (fifo_clear),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count),
    .head  (head_entry)
  );

  assign full  = fifo_full;
  assign empty = fifo_empty;

  // Update address/direction and redirect PC hold their last value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd         <= 1'b0;
      upd_addr    <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      err         <= 1'b0;
    end else begin
      upd        <= do_resolve;
      mispredict <= wrong;
      if (do_resolve) begin
        upd_addr  <= head_entry.idx;
        upd_taken <= resolve_taken;
      end
      if (wrong)
        redirect_pc <= resolve_taken ? head_entry.target : head_entry.fall;
      if ((push && fifo_full && !do_resolve) || (resolve && fifo_empty))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue: a queue-based model
// predicts every table update, and a negedge monitor scores the DUT against it.
module tb_branch_resolve_queue;

  localparam int HW    = 3;
  localparam int DEPTH = 4;
  localparam int PW    = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            push = 1'b0;
  logic [HW-1:0]   push_idx = '0;
  logic [1:0]      push_rec = '0;
  logic [PW-1:0]   push_target = '0;
  logic [PW-1:0]   push_fall = '0;
  logic            resolve = 1'b0;
  logic            resolve_taken = 1'b0;
  logic            flush = 1'b0;
  logic            full;
  logic            empty;
  logic [2:0]      count;
  logic            upd;
  logic [HW-1:0]   upd_addr;
  logic            upd_taken;
  logic            mispredict;
  logic [PW-1:0]   redirect_pc;
  logic            err;

  branch_resolve_queue #(.HISTORY_WIDTH(HW), .DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .push(push), .push_idx(push_idx), .push_rec(push_rec),
    .push_target(push_target), .push_fall(push_fall), .resolve(resolve),
    .resolve_taken(resolve_taken), .flush(flush), .full(full), .empty(empty),
    .count(count), .upd(upd), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HW-1:0] idx;
    logic [1:0]    rec;
    logic [PW-1:0] target;
    logic [PW-1:0] fall;
  } ent_t;

  typedef struct {
    logic [HW-1:0] addr;
    logic          taken;
    logic          mis;
  } exp_t;

  ent_t          mq[$];
  exp_t          sb[$];
  logic          m_err = 1'b0;
  logic [PW-1:0] m_redirect = '0;
  logic          mon_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus; the model steps on the same edge the DUT samples.
  task automatic applyStimulus(input logic r, input logic p, input int idx, input int rec,
                               input int tgt, input int fl_pc, input logic res,
                               input logic tk, input logic fl);
    ent_t e;
    exp_t x;
    logic res_ok;
    logic mis;
    int   size_before;
    rst = r; push = p; push_idx = HW'(idx); push_rec = 2'(rec);
    push_target = PW'(tgt); push_fall = PW'(fl_pc);
    resolve = res; resolve_taken = tk; flush = fl;
    @(posedge clk);
    if (r) begin
      mq.delete();
      sb.delete();
      m_err = 1'b0;
      m_redirect = '0;
    end else begin
      size_before = mq.size();
      res_ok = res && (size_before > 0);
      mis = 1'b0;
      if (res && size_before == 0) m_err = 1'b1;
      if (p && size_before == DEPTH && !res_ok) m_err = 1'b1;
      if (res_ok) begin
        e = mq.pop_front();
        mis = (e.rec[1] != tk);
        if (mis) m_redirect = tk ? e.target : e.fall;
        x.addr = e.idx; x.taken = tk; x.mis = mis;
        sb.push_back(x);
      end
      if (p && !fl && !mis && (size_before < DEPTH || res_ok)) begin
        e.idx = HW'(idx); e.rec = 2'(rec); e.target = PW'(tgt); e.fall = PW'(fl_pc);
        mq.push_back(e);
      end
      if (fl || mis) mq.delete();
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doPush(input int idx, input int rec, input int tgt, input int fl_pc);
    applyStimulus(0, 1, idx, rec, tgt, fl_pc, 0, 0, 0);
  endtask

  task automatic doResolve(input logic tk);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, tk, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Status is compared every cycle; updates are popped only when the DUT pulses upd.
  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      checkOutput("count", 32'(count), 32'(mq.size()));
      checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
      checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
      checkOutput("err", 32'(err), 32'(m_err));
      checkOutput("redirect_pc", 32'(redirect_pc), 32'(m_redirect));
      if (upd) begin
        if (sb.size() == 0) begin
          checkOutput("upd_spurious", 32'(upd), 32'd0);
        end else begin
          x = sb.pop_front();
          checkOutput("upd_addr", 32'(upd_addr), 32'(x.addr));
          checkOutput("upd_taken", 32'(upd_taken), 32'(x.taken));
          checkOutput("mispredict", 32'(mispredict), 32'(x.mis));
        end
      end else begin
        if (sb.size() != 0) begin
          checkOutput("upd_missing", 32'(upd), 32'd1);
          sb.delete();
        end
        checkOutput("mispredict_idle", 32'(mispredict), 32'd0);
      end
    end
  end

  initial begin
    int p_idx;
    logic p_push, p_res, p_fl, p_tk;
    int p_rec;

    doReset();
    mon_en = 1'b1;
    idle();

    doPush(5, 3, 'h120, 'h041);
    doResolve(1);
    idle();

    doPush(2, 1, 'h0a2, 'h013);
    doPush(6, 0, 'h0b6, 'h017);
    doPush(1, 2, 'h0c1, 'h019);
    doResolve(1);
    idle();
    doResolve(0);
    idle();

    doReset();
    for (int i = 0; i < DEPTH; i++) doPush(i, 3, 'h100 + i, 'h200 + i);
    doPush(7, 3, 'h3ff, 'h001);
    applyStimulus(0, 1, 4, 3, 'h104, 'h204, 1, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, (5 + i) % 8, 3, 'h110 + i, 'h210 + i, 1, 1, 0);
    idle();

    doReset();
    doPush(3, 2, 'h133, 'h0f3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle();
    doPush(4, 1, 'h144, 'h0f4);
    applyStimulus(0, 1, 6, 1, 'h166, 'h0f6, 0, 0, 1);
    idle();

    doPush(1, 3, 'h111, 'h011);
    doPush(2, 3, 'h122, 'h022);
    doResolve(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0);
    doResolve(1);
    idle();

    for (int i = 0; i < 400; i++) begin
      p_push = ($urandom_range(0, 99) < 60);
      p_res  = ($urandom_range(0, 99) < 45);
      p_fl   = ($urandom_range(0, 99) < 4);
      p_idx  = $urandom_range(0, 7);
      p_rec  = $urandom_range(0, 3);
      p_tk   = (mq.size() > 0 && $urandom_range(0, 99) < 85) ? mq[0].rec[1] : 1'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 99) < 2), p_push, p_idx, p_rec,
                    $urandom_range(0, 1023), $urandom_range(0, 1023), p_res, p_tk, p_fl);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
